// File: rtl/countdown_ctrl.sv
// countdown_ctrl: button edge detection, IDLE/EDIT/RUN/PAUSE/DONE sequencing and
// BCD HH:MM:SS countdown with a selectable prescaler.
module countdown_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int QUICK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    input  logic       modify,
    input  logic       quick,
    output logic [3:0] hr_10,
    output logic [3:0] hr_1,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [3:0] sec_10,
    output logic [3:0] sec_1,
    output logic [2:0] cursor,
    output logic       editing,
    output logic       running,
    output logic       alarm
);
    typedef enum logic [2:0] {IDLE, EDIT, RUN, PAUSE, DONE} state_t;
    localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
    localparam logic [31:0] QUICK_LAST = 32'(QUICK_DIV - 1);
    state_t          state, state_n;
    logic [5:0]      s1, s2, prev, pulse;
    logic [5:0][3:0] dig, dig_n, dec;
    logic [2:0]      cursor_n;
    logic [31:0]     presc, presc_n;
    logic            p_mod, p_start, p_left, p_right, p_up, p_down;
    logic            nonzero, tick, borrow;

    function automatic logic [3:0] top(input logic [2:0] i);
        top = (i == 3'd1 || i == 3'd3) ? 4'd5 : 4'd9;
    endfunction

    // pulse bits are {modify, start, left, right, up, down}; higher groups mask lower ones
    assign pulse   = s2 & ~prev;
    assign p_mod   = pulse[5];
    assign p_start = pulse[4] & ~pulse[5];
    assign p_left  = pulse[3] & ~pulse[2] & ~|pulse[5:4];
    assign p_right = pulse[2] & ~pulse[3] & ~|pulse[5:4];
    assign p_up    = pulse[1] & ~pulse[0] & ~|pulse[5:2];
    assign p_down  = pulse[0] & ~pulse[1] & ~|pulse[5:2];
    assign nonzero = |dig;
    assign tick    = presc >= (quick ? QUICK_LAST : TICK_LAST);
    assign {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = dig;

    always_comb begin
        dec = dig;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                dec[i] = dig[i] == 4'd0 ? top(3'(i)) : dig[i] - 4'd1;
                borrow = dig[i] == 4'd0;
            end
        end
    end

    always_comb begin
        state_n  = state;
        dig_n    = dig;
        cursor_n = cursor;
        presc_n  = presc;
        case (state)
            IDLE: begin
                if (p_mod) begin
                    state_n  = EDIT;
                    cursor_n = 3'd0;
                end else if (p_start && nonzero) begin
                    state_n = RUN;
                    presc_n = '0;
                end
            end
            EDIT: begin
                if (p_mod)
                    state_n = IDLE;
                else if (p_start) begin
                    state_n = nonzero ? RUN : IDLE;
                    presc_n = '0;
                end else if (p_left)
                    cursor_n = cursor == 3'd5 ? 3'd0 : cursor + 3'd1;
                else if (p_right)
                    cursor_n = cursor == 3'd0 ? 3'd5 : cursor - 3'd1;
                else if (p_up)
                    dig_n[cursor] = dig[cursor] == top(cursor) ? 4'd0 : dig[cursor] + 4'd1;
                else if (p_down)
                    dig_n[cursor] = dig[cursor] == 4'd0 ? top(cursor) : dig[cursor] - 4'd1;
            end
            RUN: begin
                if (p_mod) begin
                    state_n  = EDIT;
                    cursor_n = 3'd0;
                    presc_n  = '0;
                end else if (p_start)
                    state_n = PAUSE;
                else if (tick) begin
                    presc_n = '0;
                    dig_n   = dec;
                    if (dec == '0) state_n = DONE;
                end else
                    presc_n = presc + 32'd1;
            end
            PAUSE, DONE: begin
                if (p_mod) begin
                    state_n  = EDIT;
                    cursor_n = 3'd0;
                end else if (p_start)
                    state_n = state == PAUSE ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dig     <= '0;
            cursor  <= '0;
            presc   <= '0;
            s1      <= '0;
            s2      <= '0;
            prev    <= '0;
            editing <= 1'b0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            s1      <= {modify, start, left, right, up, down};
            s2      <= s1;
            prev    <= s2;
            state   <= state_n;
            dig     <= dig_n;
            cursor  <= cursor_n;
            presc   <= presc_n;
            editing <= state_n == EDIT;
            running <= state_n == RUN;
            alarm   <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed scenario tasks for countdown_ctrl with TICK_DIV=4, QUICK_DIV=2.
module tb_countdown_ctrl;
    localparam logic [5:0] M_MOD = 6'b100000, M_START = 6'b010000, M_LEFT = 6'b001000;
    localparam logic [5:0] M_RIGHT = 6'b000100, M_UP = 6'b000010, M_DOWN = 6'b000001;
    logic        clk = 1'b0, reset = 1'b0, quick = 1'b0;
    logic [5:0]  btn = '0;
    logic [3:0]  hr_10, hr_1, min_10, min_1, sec_10, sec_1;
    logic [2:0]  cursor, flags;
    logic        editing, running, alarm;
    logic [23:0] tm;
    int          total = 0, bad = 0;

    assign tm    = {hr_10, hr_1, min_10, min_1, sec_10, sec_1};
    assign flags = {editing, running, alarm};

    countdown_ctrl #(.TICK_DIV(4), .QUICK_DIV(2)) dut (
        .clk(clk), .reset(reset), .up(btn[1]), .down(btn[0]), .left(btn[3]),
        .right(btn[2]), .start(btn[4]), .modify(btn[5]), .quick(quick),
        .hr_10(hr_10), .hr_1(hr_1), .min_10(min_10), .min_1(min_1),
        .sec_10(sec_10), .sec_1(sec_1), .cursor(cursor),
        .editing(editing), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // returns 1 time unit after the edge on which the press takes effect
    task press_raw(input logic [5:0] m);
        @(negedge clk);
        btn = m;
        repeat (3) @(posedge clk);
        #1;
        btn = '0;
    endtask

    task press(input logic [5:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            press_raw(m);
            repeat (3) @(negedge clk);
        end
    endtask

    task test_reset;
        repeat (3) @(negedge clk);
        total++; if (tm !== 24'h0) begin bad++; $display("FAIL reset_tm got=%h want=000000", tm); end
        total++; if (cursor !== 3'd0) begin bad++; $display("FAIL reset_cursor got=%0d want=0", cursor); end
        total++; if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", flags); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (flags !== 3'b000 || tm !== 24'h0) begin bad++; $display("FAIL post_release got=%b/%h want=000/000000", flags, tm); end
    endtask

    task test_countdown;
        press(M_MOD, 1);
        total++; if (flags !== 3'b100 || cursor !== 3'd0) begin bad++; $display("FAIL edit_enter got=%b/%0d want=100/0", flags, cursor); end
        press(M_LEFT, 2);
        total++; if (cursor !== 3'd2) begin bad++; $display("FAIL left2 got=%0d want=2", cursor); end
        press(M_UP, 1);
        total++; if (tm !== 24'h000100) begin bad++; $display("FAIL set_min1 got=%h want=000100", tm); end
        press_raw(M_START);
        total++; if (flags !== 3'b010 || tm !== 24'h000100) begin bad++; $display("FAIL run_enter got=%b/%h want=010/000100", flags, tm); end
        repeat (3) @(posedge clk); #1;
        total++; if (tm !== 24'h000100) begin bad++; $display("FAIL pre_tick got=%h want=000100", tm); end
        @(posedge clk); #1;
        total++; if (tm !== 24'h000059) begin bad++; $display("FAIL first_tick got=%h want=000059", tm); end
        repeat (235) @(posedge clk); #1;
        total++; if (tm !== 24'h000001 || flags !== 3'b010) begin bad++; $display("FAIL pre_done got=%h/%b want=000001/010", tm, flags); end
        @(posedge clk); #1;
        total++; if (tm !== 24'h0 || flags !== 3'b001) begin bad++; $display("FAIL done got=%h/%b want=000000/001", tm, flags); end
        press(M_UP, 1);
        total++; if (tm !== 24'h0 || flags !== 3'b001) begin bad++; $display("FAIL done_up_ignored got=%h/%b want=000000/001", tm, flags); end
        press(M_START, 1);
        total++; if (flags !== 3'b000) begin bad++; $display("FAIL done_to_idle got=%b want=000", flags); end
        press(M_START, 1);
        total++; if (flags !== 3'b000) begin bad++; $display("FAIL idle_start_zero got=%b want=000", flags); end
    endtask

    task test_edit;
        press(M_MOD, 1);
        press(M_RIGHT, 1);
        total++; if (cursor !== 3'd5) begin bad++; $display("FAIL right_wrap got=%0d want=5", cursor); end
        press(M_UP, 9);
        total++; if (tm !== 24'h900000) begin bad++; $display("FAIL hr10_nine got=%h want=900000", tm); end
        press(M_UP, 1);
        total++; if (tm !== 24'h000000) begin bad++; $display("FAIL hr10_wrap got=%h want=000000", tm); end
        press(M_LEFT, 1);
        total++; if (cursor !== 3'd0) begin bad++; $display("FAIL left_wrap got=%0d want=0", cursor); end
        press(M_LEFT, 1);
        press(M_DOWN, 1);
        total++; if (tm !== 24'h000050) begin bad++; $display("FAIL sec10_down_wrap got=%h want=000050", tm); end
        press(M_RIGHT, 1);
        press(M_DOWN, 1);
        total++; if (tm !== 24'h000059) begin bad++; $display("FAIL sec1_down_wrap got=%h want=000059", tm); end
        press(M_MOD, 1);
        total++; if (flags !== 3'b000 || tm !== 24'h000059) begin bad++; $display("FAIL edit_leave got=%b/%h want=000/000059", flags, tm); end
    endtask

    task test_quick;
        press(M_MOD, 1);
        press(M_UP, 1);
        press(M_LEFT, 1);
        press(M_UP, 1);
        press(M_LEFT, 3);
        press(M_UP, 1);
        total++; if (tm !== 24'h010000 || cursor !== 3'd4) begin bad++; $display("FAIL load_1h got=%h/%0d want=010000/4", tm, cursor); end
        quick = 1'b1;
        press_raw(M_START);
        @(posedge clk); #1;
        total++; if (tm !== 24'h010000) begin bad++; $display("FAIL quick_pre got=%h want=010000", tm); end
        @(posedge clk); #1;
        total++; if (tm !== 24'h005959) begin bad++; $display("FAIL quick_borrow got=%h want=005959", tm); end
        @(posedge clk); #1;
        quick = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++; if (tm !== 24'h005959) begin bad++; $display("FAIL slow_pre got=%h want=005959", tm); end
        @(posedge clk); #1;
        total++; if (tm !== 24'h005958) begin bad++; $display("FAIL slow_tick got=%h want=005958", tm); end
        repeat (2) @(posedge clk); #1;
        quick = 1'b1;
        @(posedge clk); #1;
        total++; if (tm !== 24'h005957) begin bad++; $display("FAIL quick_ge got=%h want=005957", tm); end
        quick = 1'b0;
    endtask

    task test_pause;
        @(posedge clk);
        press_raw(M_START);
        total++; if (flags !== 3'b000 || tm !== 24'h005957) begin bad++; $display("FAIL pause_enter got=%b/%h want=000/005957", flags, tm); end
        total++; if (cursor !== 3'd4) begin bad++; $display("FAIL cursor_hold got=%0d want=4", cursor); end
        repeat (1000) @(negedge clk);
        total++; if (tm !== 24'h005957) begin bad++; $display("FAIL pause_frozen got=%h want=005957", tm); end
        press_raw(M_START);
        total++; if (flags !== 3'b010 || tm !== 24'h005957) begin bad++; $display("FAIL resume got=%b/%h want=010/005957", flags, tm); end
        @(posedge clk); #1;
        total++; if (tm !== 24'h005956) begin bad++; $display("FAIL resume_tick got=%h want=005956", tm); end
    endtask

    task test_priority;
        press_raw(M_MOD | M_START);
        total++; if (flags !== 3'b100 || cursor !== 3'd0 || tm !== 24'h005956) begin bad++; $display("FAIL mod_over_start got=%b/%0d/%h want=100/0/005956", flags, cursor, tm); end
        repeat (3) @(negedge clk);
        press(M_LEFT | M_UP, 1);
        total++; if (cursor !== 3'd1 || tm !== 24'h005956) begin bad++; $display("FAIL left_over_up got=%0d/%h want=1/005956", cursor, tm); end
        press(M_LEFT | M_RIGHT, 1);
        total++; if (cursor !== 3'd1) begin bad++; $display("FAIL left_right_both got=%0d want=1", cursor); end
        press(M_RIGHT, 1);
        @(negedge clk);
        btn = M_UP;
        repeat (50) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        total++; if (tm !== 24'h005957) begin bad++; $display("FAIL held_once got=%h want=005957", tm); end
    endtask

    task test_reset_run;
        press(M_DOWN, 1);
        press(M_LEFT, 2);
        press(M_DOWN, 5);
        press(M_LEFT, 1);
        press(M_DOWN, 2);
        press(M_LEFT, 1);
        press(M_UP, 2);
        press(M_LEFT, 1);
        press(M_UP, 1);
        total++; if (tm !== 24'h123456) begin bad++; $display("FAIL load_123456 got=%h want=123456", tm); end
        press_raw(M_START);
        @(posedge clk); #1;
        total++; if (flags !== 3'b010 || tm !== 24'h123456) begin bad++; $display("FAIL run_123456 got=%b/%h want=010/123456", flags, tm); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (tm !== 24'h0 || flags !== 3'b000 || cursor !== 3'd0) begin bad++; $display("FAIL async_reset got=%h/%b/%0d want=000000/000/0", tm, flags, cursor); end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (tm !== 24'h0 || flags !== 3'b000) begin bad++; $display("FAIL after_reset got=%h/%b want=000000/000", tm, flags); end
    endtask

    initial begin
        test_reset;
        test_countdown;
        test_edit;
        test_quick;
        test_pause;
        test_priority;
        test_reset_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Control and sequencing block for the front-panel countdown timer. It owns the six BCD time digits and edge-detects the raw push-buttons. It runs the IDLE/EDIT/RUN/PAUSE/DONE state machine, generates the 1 Hz (or quick) decrement tick, and raises the alarm at 00:00:00. Digit outputs drive the existing 7-segment scan/display path directly.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown step in normal mode
QUICK_DIV, 2, clk cycles per countdown step when quick=1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (clears all state while 0)
up  input  1  raw button, increments selected digit in EDIT
down  input  1  raw button, decrements selected digit in EDIT
left  input  1  raw button, moves cursor to next-higher digit
right  input  1  raw button, moves cursor to next-lower digit
start  input  1  raw button, start/pause toggle
modify  input  1  raw button, enter/leave EDIT
quick  input  1  level, selects QUICK_DIV prescale
hr_10, hr_1, min_10, min_1, sec_10, sec_1  output  4 each  BCD time digits
cursor  output  3  selected digit in EDIT: 0=sec_1, 1=sec_10, 2=min_1, 3=min_10, 4=hr_1, 5=hr_10
editing  output  1  high in EDIT
running  output  1  high in RUN
alarm  output  1  high in DONE

Behaviour:
- Reset (reset=0, async): state=IDLE, all digits 0, cursor 0, prescaler 0, editing/running/alarm 0, all synchroniser and edge registers 0.
- Per button: 2-FF synchroniser, then a previous-value register. Pulse = sync2 & ~prev, one cycle wide per press. Action lands 3 clk edges after the input first goes high. Holding a button gives exactly one action.
- Same-cycle pulse priority: modify > start > left/right > up/down. Only the highest-priority pulse acts. Others are discarded, not queued. left+right together: both ignored.
- States (encoding 0..4):
  - IDLE: modify -> EDIT, cursor=0. start with time nonzero -> RUN, prescaler=0. start with time zero -> stay IDLE.
  - EDIT: left: cursor+1, 5 wraps to 0. right: cursor-1, 0 wraps to 5.
  - EDIT up/down: inc/dec the selected digit with wrap. sec_1, min_1, hr_1, hr_10 use 0..9 (9->0, 0->9). sec_10, min_10 use 0..5 (5->0, 0->5). No carry or borrow into neighbouring digits.
  - EDIT modify -> IDLE. EDIT start: time nonzero -> RUN with prescaler=0, else -> IDLE.
  - RUN: prescaler counts every clk. When prescaler >= (quick ? QUICK_DIV : TICK_DIV) - 1, it clears and a tick fires. Using >= makes toggling quick mid-count safe.
  - RUN tick: decrement the HH:MM:SS value by 1 s in BCD. Borrow chain: sec_1 0->9, sec_10 0->5, min_1 0->9, min_10 0->5, hr_1 0->9, hr_10 0->9.
  - RUN: if a tick leaves 00:00:00, go to DONE on the same edge the digits become 0.
  - RUN start -> PAUSE; prescaler holds and any tick in that cycle is dropped. RUN modify -> EDIT, cursor=0, prescaler=0.
  - PAUSE: digits and prescaler frozen. start -> RUN, resuming the prescaler. modify -> EDIT, cursor=0.
  - DONE: alarm=1, digits 00:00:00. start -> IDLE. modify -> EDIT, cursor=0. alarm drops on leaving. up/down/left/right ignored.
- Outside EDIT, up/down/left/right are ignored and cursor holds its value. cursor resets to 0 only on entry to EDIT.
- Maximum settable value 99:59:59. Digits are always valid BCD within the ranges above.
- editing, running and alarm are registered decodes of the state, valid the same cycle as the state.
- Reset mid-RUN: immediate async clear to IDLE with 00:00:00. The first action after release needs a fresh press edge.

Test Plan:
- Reset, then EDIT: set min_1=1 (modify, left x2, up), start with TICK_DIV=4, quick=0 -> running=1; 00:01:00 -> 00:00:59 after 4 clks; DONE and alarm=1 exactly 240 clks after RUN entry; start -> IDLE, alarm=0.
- In EDIT: right at cursor 0 -> cursor 5. up x10 on hr_10 -> wraps to 0. down on sec_10 from 0 -> 5. Neighbour digits unchanged.
- Load 01:00:00, run with quick=1 (QUICK_DIV=2): after one tick, 00:59:59 (full borrow chain). Toggle quick to 0 mid-count -> next tick follows TICK_DIV, no missed or double tick.
- Run, press start -> PAUSE, digits frozen 1000 clks; start again -> resumes with remaining prescale, no extra decrement.
- Same-cycle modify+start in RUN -> EDIT, cursor=0. start at 00:00:00 in IDLE -> stays IDLE. A 50-cycle held press -> exactly one action.
- Drop reset to 0 mid-RUN at 12:34:56 -> all outputs 0 and state IDLE asynchronously, before the next clk edge.
